// File: rtl/rhd_spi_master_if.sv
// Command/result bus of rhd_spi_master: command handshake, SPI pins and
// captured result words.
interface rhd_spi_master_if;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        CS;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        rx_valid;
  logic [15:0] rx_data_a;
  logic [15:0] rx_data_b;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_data, MISO,
    output cmd_ready, CS, SCLK, MOSI, rx_valid, rx_data_a, rx_data_b, busy
  );

  modport slave (
    output cmd_valid, cmd_data, MISO,
    input  cmd_ready, CS, SCLK, MOSI, rx_valid, rx_data_a, rx_data_b, busy
  );
endinterface

// File: rtl/rhd_spi_master.sv
// 16-bit SPI master (CPOL=0) for RHD-style converters, one command per frame.
// Define RHD_SPI_MASTER_DDR_EN to also capture the second device on SCLK low halves.
module rhd_spi_master #(
  parameter int CLK_DIV        = 4,
  parameter int CS_HIGH_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rstn,
  rhd_spi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_HIGH_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic        cs_q, sclk_q, mosi_q, rx_valid_q;
  logic [15:0] rx_a_q;
  logic [14:0] sh_tx;
  logic [15:0] sh_a;
  logic        phase_end, lo_end, hi_end;

  assign phase_end = (cnt == DIV_LAST);
  assign lo_end    = (state == SHIFT_LO) && phase_end;
  assign hi_end    = (state == SHIFT_HI) && phase_end;

  // Control: FSM and all pin/flag flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_a_q     <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      cnt        <= cnt + 8'd1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.cmd_valid) begin
            state   <= SETUP;
            cs_q    <= 1'b0;
            mosi_q  <= bus.cmd_data[15];
            bit_cnt <= '0;
          end
        end
        SETUP: if (phase_end) begin
          state <= SHIFT_LO;
          cnt   <= '0;
        end
        SHIFT_LO: if (phase_end) begin
          state  <= SHIFT_HI;
          cnt    <= '0;
          sclk_q <= 1'b1;
        end
        SHIFT_HI: if (phase_end) begin
          cnt    <= '0;
          sclk_q <= 1'b0;
          if (bit_cnt == 4'd15) begin
            state <= HOLD;
          end else begin
            state   <= SHIFT_LO;
            bit_cnt <= bit_cnt + 4'd1;
            mosi_q  <= sh_tx[14];
          end
        end
        HOLD: if (phase_end) begin
          state      <= GAP;
          cnt        <= '0;
          cs_q       <= 1'b1;
          mosi_q     <= 1'b0;
          rx_valid_q <= 1'b1;
          rx_a_q     <= sh_a;
        end
        GAP: if (cnt == GAP_LAST) begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: shift registers; the command is reloaded on every IDLE cycle so the
  // accepted word is whatever was on cmd_data in the accepting cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      sh_tx <= bus.cmd_data[14:0];
    end else if (hi_end) begin
      sh_tx <= {sh_tx[13:0], 1'b0};
    end
    if (hi_end) begin
      sh_a <= {sh_a[14:0], bus.MISO};
    end
  end

`ifdef RHD_SPI_MASTER_DDR_EN
  logic [14:0] sh_b;
  logic [15:0] rx_b_q;

  // The SHIFT_LO ahead of the first high half also shifts in a bit; it falls
  // off the top, leaving the 15 low-half samples that follow a high half.
  always_ff @(posedge clk) begin
    if (lo_end) begin
      sh_b <= {sh_b[13:0], bus.MISO};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_b_q <= '0;
    end else if ((state == HOLD) && phase_end) begin
      rx_b_q <= {sh_b, bus.MISO};
    end
  end

  assign bus.rx_data_b = rx_b_q;
`else
  assign bus.rx_data_b = '0;
`endif

  assign bus.cmd_ready = rstn && (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.CS        = cs_q;
  assign bus.SCLK      = sclk_q;
  assign bus.MOSI      = mosi_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data_a = rx_a_q;

endmodule
